hangman_draw_engine: RTL and testbench
======================================

// Module: hangman_draw_engine
// PURPOSE
// - Sits downstream of the guess datapath and upstream of vga_adapter (160x120, 3-bit colour).
// - Accepts one draw request at a time and turns it into a raster stream of (x, y, colour, plot), one pixel per clk.
// - Request kinds:
//   - unmask a letter slot: filled box under the word line;
//   - draw one hangman body part: part n of 6, drawn after the n-th wrong guess;
//   - clear the whole screen to black, for a new game.
// PARAMETERS
// X_BASE      42   x of slot-0 origin; slot i origin x = X_BASE + SLOT_PITCH*i
// Y_LETTER    100  top y of letter boxes
// SLOT_PITCH  5    horizontal pitch between letter slots
// BOX_W       4    letter box width (pixels)
// BOX_H       5    letter box height (pixels)
// HANG_X      20   x origin of hangman figure
// HANG_Y      20   y origin of hangman figure
// PORTS
// clk         in   1  system clock (CLOCK_50)
// resetn      in   1  synchronous, active-low reset
// req_valid   in   1  request present; sampled only while req_ready=1
// req_ready   out  1  high only in IDLE
// req_kind    in   2  00 letter, 01 hangman part, 10 clear screen, 11 reserved
// req_index   in   3  letter slot 1..5 or hangman part 1..6; ignored for clear
// x           out  8  pixel x to vga_adapter
// y           out  7  pixel y to vga_adapter
// colour      out  3  pixel colour
// plot        out  1  write strobe; x/y/colour valid when high
// busy        out  1  high from accept until done pulse inclusive
// done        out  1  one-cycle pulse when request fully drawn
// BEHAVIOUR
// - Reset values: state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0, req_ready=1. A reset mid-request aborts it; the next cycle has plot=0 and no done pulse.
// - FSM states: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//   - IDLE: req_ready=1. Accept on req_valid&req_ready; kind/index are latched on that edge. req_valid while not IDLE is ignored (not queued).
//   - LOAD (1 cycle): compute origin (ox,oy), width W, height H and colour from the latched request; reset col=0, row=0.
//   - DRAW: each cycle plot=1, x=ox+col, y=oy+row. col increments first; at col=W-1, col->0 and row++. The last pixel is (W-1,H-1); exactly W*H plot cycles.
//   - DONE: plot=0, done=1 for one cycle; then IDLE.
// - Latency: accept at edge N; first plot cycle at N+2; done at N+2+W*H.
// - Letter (kind 00), colour 3'b010: origin (X_BASE+SLOT_PITCH*idx, Y_LETTER), size BOX_W x BOX_H.
// - Hangman (kind 01), colour 3'b111. Rectangles as (dx,dy,W,H) relative to HANG_X/HANG_Y:
//   1 head (2,0,5,5); 2 body (4,5,1,10); 3 left arm (0,7,4,1); 4 right arm (5,7,4,1);
//   5 left leg (2,15,2,6); 6 right leg (5,15,2,6).
// - Clear (kind 10), colour 3'b000: origin (0,0), size 160x120; 19200 plot cycles.
// - Invalid request (letter idx 0/6/7, part idx 0/7, kind 11): accepted, LOAD skips DRAW, no plot, done still pulses at N+2.
// - Arithmetic: coords computed in 8 bits. Parameters must keep every pixel inside 0..159 x 0..119; y is truncated to 7 bits.
// - Outputs are registered; plot never asserts outside DRAW.
// TESTING
// - Reset, then letter kind=00 idx=1 -> plot 1st at N+2 with x=47,y=100,colour=010; 20 pixels ending x=50,y=104; done at N+22.
// - Part kind=01 idx=2 -> 10 plots, x=24, y=25..34, colour=111; busy high N+1..N+12 inclusive.
// - Part kind=01 idx=7 (invalid) -> zero plots; done pulse at N+2; req_ready back high N+3.
// - req_valid held high through a letter draw, idx changed mid-draw -> only the first request drawn; the second accepted only after IDLE.
// - Clear kind=10 -> 19200 plots, first (0,0), last (159,119), all colour=000; done at N+19202.
// - resetn low during clear at pixel 500 -> plot=0 next cycle, no done, req_ready=1; a new letter request draws normally.

Source files
------------

// File: rtl/hangman_draw_if.sv
// Request/raster bundle between the guess datapath, the draw engine
// and the VGA adapter.
interface hangman_draw_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_kind;
    logic [2:0] req_index;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_kind, req_index,
        input  req_ready, x, y, colour, plot, busy, done
    );

    modport slave (
        input  req_valid, req_kind, req_index,
        output req_ready, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/hangman_draw_engine.sv
// Turns one letter / hangman-part / clear request into a filled
// rectangle raster, one registered pixel per clock.
module hangman_draw_engine #(
    parameter int X_BASE     = 42,
    parameter int Y_LETTER   = 100,
    parameter int SLOT_PITCH = 5,
    parameter int BOX_W      = 4,
    parameter int BOX_H      = 5,
    parameter int HANG_X     = 20,
    parameter int HANG_Y     = 20
) (
    input logic          clk,
    input logic          resetn,
    hangman_draw_if.slave bus
);
    localparam logic [7:0] XB = 8'(X_BASE);
    localparam logic [7:0] YL = 8'(Y_LETTER);
    localparam logic [7:0] SP = 8'(SLOT_PITCH);
    localparam logic [7:0] BW = 8'(BOX_W);
    localparam logic [7:0] BH = 8'(BOX_H);
    localparam logic [7:0] HX = 8'(HANG_X);
    localparam logic [7:0] HY = 8'(HANG_Y);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t     state, state_n;
    logic [1:0] kind_q;
    logic [2:0] idx_q;
    logic [7:0] ox, oy, w, h, col, row;
    logic [7:0] ox_n, oy_n, w_n, h_n, col_n, row_n;
    logic [2:0] pcol, pcol_n;
    logic [7:0] dox, doy, dw, dh;
    logic [2:0] dcol;
    logic       dok;

    // Map the latched request onto a rectangle; dok=0 means nothing to draw
    always_comb begin
        dox  = '0;
        doy  = '0;
        dw   = '0;
        dh   = '0;
        dcol = '0;
        dok  = 1'b0;
        case (kind_q)
            2'b00: begin
                dox  = XB + SP * {5'd0, idx_q};
                doy  = YL;
                dw   = BW;
                dh   = BH;
                dcol = 3'b010;
                dok  = (idx_q >= 3'd1) && (idx_q <= 3'd5);
            end
            2'b01: begin
                dcol = 3'b111;
                dok  = 1'b1;
                case (idx_q)
                    3'd1: {dox, doy, dw, dh} = {HX + 8'd2, HY, 8'd5, 8'd5};
                    3'd2: {dox, doy, dw, dh} = {HX + 8'd4, HY + 8'd5, 8'd1, 8'd10};
                    3'd3: {dox, doy, dw, dh} = {HX, HY + 8'd7, 8'd4, 8'd1};
                    3'd4: {dox, doy, dw, dh} = {HX + 8'd5, HY + 8'd7, 8'd4, 8'd1};
                    3'd5: {dox, doy, dw, dh} = {HX + 8'd2, HY + 8'd15, 8'd2, 8'd6};
                    3'd6: {dox, doy, dw, dh} = {HX + 8'd5, HY + 8'd15, 8'd2, 8'd6};
                    default: dok = 1'b0;
                endcase
            end
            2'b10: begin
                dw  = 8'd160;
                dh  = 8'd120;
                dok = 1'b1;
            end
            default: dok = 1'b0;
        endcase
    end

    // Next state plus next raster position; counters name the pixel on screen
    always_comb begin
        state_n = state;
        ox_n    = ox;
        oy_n    = oy;
        w_n     = w;
        h_n     = h;
        pcol_n  = pcol;
        col_n   = col;
        row_n   = row;
        case (state)
            IDLE: if (bus.req_valid) state_n = LOAD;
            LOAD: begin
                ox_n    = dox;
                oy_n    = doy;
                w_n     = dw;
                h_n     = dh;
                pcol_n  = dcol;
                col_n   = '0;
                row_n   = '0;
                state_n = dok ? DRAW : DONE;
            end
            DRAW: begin
                if (col == w - 8'd1) begin
                    col_n = '0;
                    if (row == h - 8'd1) state_n = DONE;
                    else                 row_n   = row + 8'd1;
                end else begin
                    col_n = col + 8'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Request latch, geometry/counters and registered raster outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            kind_q        <= '0;
            idx_q         <= '0;
            ox            <= '0;
            oy            <= '0;
            w             <= '0;
            h             <= '0;
            pcol          <= '0;
            col           <= '0;
            row           <= '0;
            bus.x         <= '0;
            bus.y         <= '0;
            bus.colour    <= '0;
            bus.plot      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                kind_q <= bus.req_kind;
                idx_q  <= bus.req_index;
            end
            ox   <= ox_n;
            oy   <= oy_n;
            w    <= w_n;
            h    <= h_n;
            pcol <= pcol_n;
            col  <= col_n;
            row  <= row_n;
            if (state_n == DRAW) begin
                bus.x      <= ox_n + col_n;
                bus.y      <= 7'(oy_n + row_n);
                bus.colour <= pcol_n;
            end
            bus.plot      <= (state_n == DRAW);
            bus.done      <= (state_n == DONE);
            bus.busy      <= (state_n != IDLE);
            bus.req_ready <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_hangman_draw_engine.sv
// Bench for hangman_draw_engine: vector table, hand sequences and
// random requests checked against a rectangle-level reference model.
module tb_hangman_draw_engine;
    logic clk;
    logic resetn;

    hangman_draw_if bus ();

    hangman_draw_engine dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit ok;
        int ox, oy, w, h, col;
    } rect_t;

    typedef struct {
        logic [1:0] k;
        logic [2:0] i;
        int n, fx, fy, lx, ly, col;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: what rectangle a request should paint
    function automatic rect_t model(input int k, input int i);
        int    dx[7] = '{0, 2, 4, 0, 5, 2, 5};
        int    dy[7] = '{0, 0, 5, 7, 7, 15, 15};
        int    pw[7] = '{0, 5, 1, 4, 4, 2, 2};
        int    ph[7] = '{0, 5, 10, 1, 1, 6, 6};
        rect_t r     = '{0, 0, 0, 0, 0, 0};
        if (k == 0 && i >= 1 && i <= 5)
            r = '{1, 42 + 5 * i, 100, 4, 5, 2};
        else if (k == 1 && i >= 1 && i <= 6)
            r = '{1, 20 + dx[i], 20 + dy[i], pw[i], ph[i], 7};
        else if (k == 2)
            r = '{1, 0, 0, 160, 120, 0};
        return r;
    endfunction

    task automatic send(input logic [1:0] k, input logic [2:0] i);
        @(negedge clk);
        chk("ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_index = i;
        @(posedge clk);
    endtask

    // Follow one request from the cycle after its accept edge to done
    task automatic collect(input rect_t r, input bit hold,
                           output int n, output int fx, output int fy,
                           output int lx, output int ly, output int col,
                           output int done_at, output int bad);
        int expn = r.ok ? r.w * r.h : 0;
        n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        col = -1; done_at = -1; bad = 0;
        for (int c = 1; c <= expn + 50; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) bus.req_valid = 1'b0;
            if (c == 5 && hold) bus.req_index = 3'd3;
            if (!bus.busy) bad++;
            if (bus.plot) begin
                if (n == 0) begin
                    fx  = int'(bus.x);
                    fy  = int'(bus.y);
                    col = int'(bus.colour);
                end
                lx = int'(bus.x);
                ly = int'(bus.y);
                if (n >= expn || c != n + 2) bad++;
                else if (int'(bus.x) != r.ox + n % r.w ||
                         int'(bus.y) != r.oy + n / r.w ||
                         int'(bus.colour) != r.col) bad++;
                n++;
            end
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        chk({tag, "_ready_after"}, int'(bus.req_ready), 1);
        chk({tag, "_busy_after"}, int'(bus.busy), 0);
        chk({tag, "_done_after"}, int'(bus.done), 0);
        chk({tag, "_plot_after"}, int'(bus.plot), 0);
    endtask

    vec_t  vecs[11];
    rect_t r;
    int    n, fx, fy, lx, ly, col, done_at, bad, expn;

    initial begin
        vecs[0]  = '{2'b00, 3'd1, 20, 47, 100, 50, 104, 2};
        vecs[1]  = '{2'b01, 3'd2, 10, 24, 25, 24, 34, 7};
        vecs[2]  = '{2'b01, 3'd7, 0, -1, -1, -1, -1, -1};
        vecs[3]  = '{2'b00, 3'd5, 20, 67, 100, 70, 104, 2};
        vecs[4]  = '{2'b01, 3'd1, 25, 22, 20, 26, 24, 7};
        vecs[5]  = '{2'b01, 3'd3, 4, 20, 27, 23, 27, 7};
        vecs[6]  = '{2'b01, 3'd6, 12, 25, 35, 26, 40, 7};
        vecs[7]  = '{2'b00, 3'd0, 0, -1, -1, -1, -1, -1};
        vecs[8]  = '{2'b00, 3'd6, 0, -1, -1, -1, -1, -1};
        vecs[9]  = '{2'b11, 3'd2, 0, -1, -1, -1, -1, -1};
        vecs[10] = '{2'b10, 3'd0, 19200, 0, 0, 159, 119, 0};

        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'b00;
        bus.req_index = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ready", int'(bus.req_ready), 1);
        resetn = 1'b1;

        foreach (vecs[v]) begin
            send(vecs[v].k, vecs[v].i);
            collect(model(vecs[v].k, vecs[v].i), 1'b0,
                    n, fx, fy, lx, ly, col, done_at, bad);
            chk($sformatf("vec%0d_count", v), n, vecs[v].n);
            chk($sformatf("vec%0d_first_x", v), fx, vecs[v].fx);
            chk($sformatf("vec%0d_first_y", v), fy, vecs[v].fy);
            chk($sformatf("vec%0d_last_x", v), lx, vecs[v].lx);
            chk($sformatf("vec%0d_last_y", v), ly, vecs[v].ly);
            chk($sformatf("vec%0d_colour", v), col, vecs[v].col);
            chk($sformatf("vec%0d_done_at", v), done_at, 2 + vecs[v].n);
            chk($sformatf("vec%0d_bad_pixels", v), bad, 0);
            post_idle($sformatf("vec%0d", v));
        end

        // req_valid held through a draw with the index changed mid-draw
        send(2'b00, 3'd1);
        collect(model(0, 1), 1'b1, n, fx, fy, lx, ly, col, done_at, bad);
        chk("hold_count", n, 20);
        chk("hold_first_x", fx, 47);
        chk("hold_last_x", lx, 50);
        chk("hold_done_at", done_at, 22);
        chk("hold_bad", bad, 0);
        @(negedge clk);
        chk("hold_ready_idle", int'(bus.req_ready), 1);
        chk("hold_plot_idle", int'(bus.plot), 0);
        @(posedge clk);
        collect(model(0, 3), 1'b0, n, fx, fy, lx, ly, col, done_at, bad);
        chk("hold2_count", n, 20);
        chk("hold2_first_x", fx, 57);
        chk("hold2_done_at", done_at, 22);
        chk("hold2_bad", bad, 0);
        post_idle("hold2");

        // Reset in the middle of a clear
        send(2'b10, 3'd0);
        n = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.plot) n++;
            if (n == 500) break;
        end
        chk("abort_reached_500", n, 500);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_ready", int'(bus.req_ready), 1);
        chk("abort_busy", int'(bus.busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_no_done", int'(bus.done), 0);
        chk("abort_no_plot", int'(bus.plot), 0);
        send(2'b00, 3'd2);
        collect(model(0, 2), 1'b0, n, fx, fy, lx, ly, col, done_at, bad);
        chk("after_abort_count", n, 20);
        chk("after_abort_first_x", fx, 52);
        chk("after_abort_done_at", done_at, 22);
        chk("after_abort_bad", bad, 0);
        post_idle("after_abort");

        // Random letters, parts and reserved kinds
        for (int t = 0; t < 25; t++) begin
            int k = $urandom_range(0, 2);
            int i = $urandom_range(0, 7);
            if (k == 2) k = 3;
            r    = model(k, i);
            expn = r.ok ? r.w * r.h : 0;
            send(2'(k), 3'(i));
            collect(r, 1'b0, n, fx, fy, lx, ly, col, done_at, bad);
            chk($sformatf("rnd%0d_k%0d_i%0d_count", t, k, i), n, expn);
            chk($sformatf("rnd%0d_done_at", t), done_at, 2 + expn);
            chk($sformatf("rnd%0d_bad", t), bad, 0);
            post_idle($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
